alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal range 4..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 sel  input  3  opcode; encoding per REQ-012.
REQ-009 out_valid  output  1  result registers hold a valid result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 r  output  WIDTH  result; zf output 1 zero flag; dz output 1 divide-by-zero flag; ovf output 1 overflow flag.

Function
REQ-012 Opcodes: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 SLT (a<b unsigned ? 1 : 0); 5 MUL; 6 DIV (unsigned quotient); 7 PASSB (r=b).
REQ-013 Accept occurs on a rising edge with in_valid && in_ready; a, b and sel are captured at that edge, and later input changes have no effect on the operation.
REQ-014 FSM states: IDLE, MUL, DIV, DONE; in_ready=1 only in IDLE.
REQ-015 IDLE, accept of opcode 0-4 or 7 -> DONE with the result registered; out_valid rises the cycle after accept (latency 1).
REQ-016 IDLE, accept of MUL -> MUL; shift-add, one multiplier bit per cycle, WIDTH cycles -> DONE; r = low WIDTH bits of the product; latency WIDTH+1.
REQ-017 IDLE, accept of DIV -> DIV; restoring division, one quotient bit per cycle, WIDTH cycles -> DONE; latency WIDTH+1.
REQ-018 DIV with b==0: still takes WIDTH+1 cycles; r = all ones; dz=1. dz=0 for every other result.
REQ-019 ADD/SUB wrap modulo 2^WIDTH.
REQ-020 zf=1 exactly when the registered r is zero; it is a registered output, valid with out_valid.
REQ-021 DONE: out_valid=1; r/zf/dz/ovf hold stable until out_ready=1; DONE && out_ready -> IDLE on that edge. No new accept in the same cycle; the earliest next accept is one cycle later.
REQ-022 in_valid while busy (MUL/DIV/DONE) is ignored and not queued; the requester holds the request until in_ready.
REQ-023 r/zf/dz/ovf are don't-care when out_valid=0, and are registered outputs with no combinational path from the inputs.

Reset
REQ-024 rst=1 at an edge -> IDLE; out_valid=0, r=0, zf=0, dz=0, ovf=0, iteration counter=0; in_ready=1 in the cycle after reset.
REQ-025 rst mid-MUL/DIV/DONE aborts the operation; no result is presented afterwards.

Configuration
REQ-026 Macro ALU_MC_OVF_EN defined: ovf = unsigned carry-out for ADD and borrow (a<b) for SUB, registered with r; ovf=0 for all other opcodes.
REQ-027 Macro ALU_MC_OVF_EN undefined: ovf is tied to 0; the port remains present and no carry logic is built.

Structure
REQ-028 Package alu_mc_pkg holds the opcode enum (OP_ADD..OP_PASSB), the FSM state enum, and the WIDTH default constant.
REQ-029 Sub-module alu_mc_div holds the iterative restoring divider (start/done, WIDTH-cycle); the multiplier stays inline.

Verification (WIDTH=32)
REQ-030 ADD a=0xFFFFFFFF, b=1 -> r=0, zf=1, out_valid one cycle after accept; ovf=1 with macro, 0 without.
REQ-031 MUL a=1234, b=5678 -> r=7006652, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
REQ-032 DIV a=100, b=7 -> r=14, dz=0; DIV a=5, b=0 -> r=0xFFFFFFFF, dz=1, latency 33.
REQ-033 Backpressure: SLT a=3, b=9 with out_ready=0 for 10 cycles -> r=1 stable, in_ready=0, new in_valid ignored; out_ready=1 -> next-cycle in_ready=1.
REQ-034 rst asserted 10 cycles into a DIV -> next cycle out_valid=0, in_ready=1; a following SUB a=2, b=3 -> r=0xFFFFFFFF, with ovf=1 when the macro is defined.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared types and constants for the multi-cycle ALU (alu_mc).
// Holds the opcode encoding, the controller state encoding and the default datapath width.
package alu_mc_pkg;

    localparam int ALU_MC_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_SLT   = 3'd4,
        OP_MUL   = 3'd5,
        OP_DIV   = 3'd6,
        OP_PASSB = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/alu_mc_div.sv
// Iterative restoring divider for alu_mc: one quotient bit per cycle, WIDTH cycles per divide.
// start captures the operands on its edge; done is high during the final iteration cycle,
// with quotient carrying the fully formed result for the parent to register on that edge.
// A zero divisor runs the full WIDTH cycles and naturally yields an all-ones quotient.
module alu_mc_div
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = ALU_MC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic             dz
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             last;

    // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = shifted - {1'b0, div_q};
        rem_step = shifted[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_step = diff[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    assign last     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign done     = last;
    assign quotient = quo_step;
    assign dz       = dz_q;

    // Load operands on start, otherwise advance one iteration per cycle while busy.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        dz_d   = dz_q;
        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            div_d  = divisor;
            cnt_d  = '0;
            busy_d = 1'b1;
            dz_d   = (divisor == '0);
        end else if (busy_q) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    // Divider state registers; reset abandons any divide in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            dz_q   <= dz_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: single-cycle ADD/SUB/AND/OR/SLT/PASSB, WIDTH-cycle shift-add MUL,
// WIDTH-cycle restoring DIV (alu_mc_div), valid/ready handshakes on both sides.
// Optional macro ALU_MC_OVF_EN: when defined, ovf reports ADD carry-out / SUB borrow;
// when undefined, ovf is tied low and no carry logic exists.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = ALU_MC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             zf,
    output logic             dz,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             zf_q, zf_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    op_e              op;
    logic             accept;
    logic [WIDTH-1:0] simple_r;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] div_r;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_quot;
    logic             div_dz;

    assign op        = op_e'(sel);
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign div_start = accept && (op == OP_DIV);
    assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign div_r     = div_dz ? '1 : div_quot;

    assign r  = r_q;
    assign zf = zf_q;
    assign dz = dz_q;

    alu_mc_div #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (a),
        .divisor  (b),
        .done     (div_done),
        .quotient (div_quot),
        .dz       (div_dz)
    );

    // Single-cycle result for the opcodes that complete on the accept edge.
    always_comb begin
        simple_r = '0;
        case (op)
            OP_ADD:   simple_r = a + b;
            OP_SUB:   simple_r = a - b;
            OP_AND:   simple_r = a & b;
            OP_OR:    simple_r = a | b;
            OP_SLT:   simple_r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_PASSB: simple_r = b;
            default:  simple_r = '0;
        endcase
    end

    // Controller: accept in IDLE, iterate in MUL/DIV, hold the result in DONE until taken.
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        zf_d     = zf_q;
        dz_d     = dz_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MUL: begin
                            acc_d    = '0;
                            mcand_d  = a;
                            mplier_d = b;
                            cnt_d    = '0;
                            state_d  = ST_MUL;
                        end
                        OP_DIV: begin
                            state_d = ST_DIV;
                        end
                        default: begin
                            r_d     = simple_r;
                            zf_d    = (simple_r == '0);
                            dz_d    = 1'b0;
                            state_d = ST_DONE;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                acc_d    = acc_step;
                mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    r_d     = acc_step;
                    zf_d    = (acc_step == '0);
                    dz_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    r_d     = div_r;
                    zf_d    = (div_r == '0);
                    dz_d    = div_dz;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller and datapath registers; reset drops any operation in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            r_q      <= '0;
            zf_q     <= 1'b0;
            dz_q     <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            zf_q     <= zf_d;
            dz_q     <= dz_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef ALU_MC_OVF_EN
    logic           ovf_q, ovf_d;
    logic [WIDTH:0] add_wide;

    // Carry/borrow is decided on the accept edge; every other opcode leaves it cleared.
    always_comb begin
        add_wide = {1'b0, a} + {1'b0, b};
        ovf_d    = ovf_q;
        if (accept) begin
            if (op == OP_ADD) begin
                ovf_d = add_wide[WIDTH];
            end else if (op == OP_SUB) begin
                ovf_d = (a < b);
            end else begin
                ovf_d = 1'b0;
            end
        end
    end

    // Overflow flag register, updated alongside the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32). Expected results come from a behavioural
// model and travel through a scoreboard queue from the accept to the output handshake.
module tb_alu_mc;
    import alu_mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] r;
    logic        zf;
    logic        dz;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] r;
        logic        zf;
        logic        dz;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_mc #(
        .WIDTH(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .zf        (zf),
        .dz        (dz),
        .ovf       (ovf)
    );

    // Single comparison point: counts, asserts, reports on mismatch.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference for one operation.
    function automatic exp_t model(input string tag, input logic [2:0] s,
                                   input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [63:0] w;
        e.tag = tag;
        e.r   = '0;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        e.lat = 1;
        case (s)
            3'd0: begin
                w   = {32'd0, x} + {32'd0, y};
                e.r = w[31:0];
`ifdef ALU_MC_OVF_EN
                e.ovf = w[32];
`endif
            end
            3'd1: begin
                e.r = x - y;
`ifdef ALU_MC_OVF_EN
                e.ovf = (x < y);
`endif
            end
            3'd2: e.r = x & y;
            3'd3: e.r = x | y;
            3'd4: e.r = (x < y) ? 32'd1 : 32'd0;
            3'd5: begin
                w     = {32'd0, x} * {32'd0, y};
                e.r   = w[31:0];
                e.lat = 33;
            end
            3'd6: begin
                e.lat = 33;
                if (y == 32'd0) begin
                    e.r  = 32'hFFFF_FFFF;
                    e.dz = 1'b1;
                end else begin
                    e.r = x / y;
                end
            end
            default: e.r = y;
        endcase
        e.zf = (e.r == 32'd0);
        return e;
    endfunction

    // Present a request at a negedge, wait for acceptance, then scramble the operands.
    task automatic applyStimulus(input string tag, input logic [2:0] s,
                                 input logic [31:0] x, input logic [31:0] y, input bit push);
        int wait_cyc = 0;
        in_valid = 1'b1;
        sel      = s;
        a        = x;
        b        = y;
        while (!in_ready && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!in_ready) begin
            chk({tag, " accept"}, in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        if (push) sb.push_back(model(tag, s, x, y));
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        sel      = 3'($urandom_range(0, 7));
    endtask

    // Wait for the result, compare against the scoreboard head, then consume it.
    task automatic checkOutput();
        exp_t e;
        int   lat        = 1;
        bit   saw_ready  = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) saw_ready = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (sb.size() == 0) begin
            chk("scoreboard empty", 64'(sb.size()), 1);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, " out_valid"}, out_valid, 1);
        chk({e.tag, " latency"}, 64'(lat), 64'(e.lat));
        chk({e.tag, " r"}, r, e.r);
        chk({e.tag, " zf"}, zf, e.zf);
        chk({e.tag, " dz"}, dz, e.dz);
        chk({e.tag, " ovf"}, ovf, e.ovf);
        if (e.lat > 1) chk({e.tag, " in_ready while busy"}, saw_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({e.tag, " in_ready after take"}, in_ready, 1);
    endtask

    initial begin
        bit          saw_valid;
        logic [2:0]  rs;
        logic [31:0] rx;
        logic [31:0] ry;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sel       = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready", in_ready, 1);
        chk("reset r", r, 0);
        chk("reset zf", zf, 0);
        chk("reset dz", dz, 0);
        chk("reset ovf", ovf, 0);

        applyStimulus("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 1);
        checkOutput();

        applyStimulus("mul", OP_MUL, 32'd1234, 32'd5678, 1);
        checkOutput();

        applyStimulus("div", OP_DIV, 32'd100, 32'd7, 1);
        checkOutput();

        applyStimulus("div_zero", OP_DIV, 32'd5, 32'd0, 1);
        checkOutput();

        applyStimulus("sub", OP_SUB, 32'd10, 32'd3, 1);
        checkOutput();
        applyStimulus("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 1);
        checkOutput();
        applyStimulus("or", OP_OR, 32'hA000_0001, 32'h0500_0010, 1);
        checkOutput();
        applyStimulus("slt_false", OP_SLT, 32'd9, 32'd3, 1);
        checkOutput();
        applyStimulus("passb", OP_PASSB, 32'h1111_1111, 32'hDEAD_BEEF, 1);
        checkOutput();
        applyStimulus("mul_big", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        checkOutput();
        applyStimulus("div_max", OP_DIV, 32'hFFFF_FFFF, 32'd1, 1);
        checkOutput();

        for (int i = 0; i < 8; i++) begin
            rs = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 300));
            applyStimulus("random", rs, rx, ry, 1);
            checkOutput();
        end

        applyStimulus("slt_bp", OP_SLT, 32'd3, 32'd9, 1);
        in_valid = 1'b1;
        sel      = OP_ADD;
        a        = 32'd1;
        b        = 32'd1;
        for (int i = 0; i < 10; i++) begin
            chk("bp r stable", r, 1);
            chk("bp in_ready", in_ready, 0);
            @(negedge clk);
        end
        checkOutput();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp ignored request", out_valid, 0);

        applyStimulus("div_abort", OP_DIV, 32'd1000, 32'd3, 0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort out_valid", out_valid, 0);
        chk("abort in_ready", in_ready, 1);
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        chk("abort no result", saw_valid, 0);

        applyStimulus("sub_after_abort", OP_SUB, 32'd2, 32'd3, 1);
        checkOutput();

        chk("scoreboard drained", 64'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
